// File: rtl/bcd_preset_counter.sv
// N-digit BCD up/down counter with a programmable wrap limit and a
// cursor-based digit editor (config mode) with commit clamp and idle timeout.
module bcd_preset_counter #(
  parameter int unsigned NUM_DIGITS  = 2,
  parameter int unsigned MAX_VALUE   = 63,
  parameter int unsigned CFG_TIMEOUT = 500_000_000,
  parameter int unsigned BLINK_HALF  = 25_000_000,
  localparam int unsigned CW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int unsigned BW = 4 * NUM_DIGITS
) (
  input  logic          clk,
  input  logic          reset_sw_n,
  input  logic          count_en,
  input  logic          inc_pulse,
  input  logic          dec_pulse,
  input  logic          cfg_pulse,
  input  logic          sel_pulse,
  input  logic          adj_up_pulse,
  input  logic          adj_dn_pulse,
  output logic [BW-1:0] bcd_out,
  output logic          cfg_mode,
  output logic [CW-1:0] cursor,
  output logic [NUM_DIGITS-1:0] blank_mask,
  output logic          wrap_pulse,
  output logic          clamp_pulse,
  output logic          timeout_pulse
);

  typedef logic [BW-1:0] bcd_t;
  typedef enum logic {S_COUNT, S_CONFIG} state_t;

  function automatic bcd_t to_bcd(input int unsigned v);
    bcd_t        r;
    int unsigned t;
    r = '0;
    t = v;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  localparam bcd_t MAX_BCD = to_bcd(MAX_VALUE);

  // Ripple +1 through the nibbles with a decimal carry.
  function automatic bcd_t bcd_inc(input bcd_t v);
    bcd_t r;
    logic c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
        else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic bcd_t bcd_dec(input bcd_t v);
    bcd_t r;
    logic b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (b) begin
        if (r[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'd9;
        else begin
          r[4*i +: 4] = r[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  state_t          r_state, w_state_nxt;
  bcd_t            r_count, w_count_nxt;
  bcd_t            r_edit, w_edit_nxt;
  logic [CW-1:0]   r_cursor, w_cursor_nxt;
  logic [31:0]     r_idle, w_idle_nxt;
  logic [31:0]     r_blink, w_blink_nxt;
  logic            r_off, w_off_nxt;
  bcd_t            r_bcd_out, w_bcd_nxt;
  logic            r_cfg_mode;
  logic [NUM_DIGITS-1:0] r_blank, w_blank_nxt;
  logic            r_wrap, w_wrap_nxt;
  logic            r_clamp, w_clamp_nxt;
  logic            r_tmo, w_tmo_nxt;
  logic            w_tmo_hit;
  logic            w_blink_hit;

  assign w_tmo_hit   = (CFG_TIMEOUT != 0) && (r_idle == 32'(CFG_TIMEOUT - 1));
  assign w_blink_hit = (r_blink >= 32'(BLINK_HALF - 1));

  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_edit_nxt   = r_edit;
    w_cursor_nxt = r_cursor;
    w_idle_nxt   = r_idle;
    w_blink_nxt  = r_blink;
    w_off_nxt    = r_off;
    w_wrap_nxt   = 1'b0;
    w_clamp_nxt  = 1'b0;
    w_tmo_nxt    = 1'b0;
    case (r_state)
      S_COUNT: begin
        w_idle_nxt  = '0;
        w_blink_nxt = '0;
        w_off_nxt   = 1'b0;
        if (cfg_pulse) begin
          w_state_nxt  = S_CONFIG;
          w_edit_nxt   = r_count;
          w_cursor_nxt = '0;
        end else if (count_en && (inc_pulse ^ dec_pulse)) begin
          if (inc_pulse) begin
            if (r_count == MAX_BCD) begin
              w_count_nxt = '0;
              w_wrap_nxt  = 1'b1;
            end else w_count_nxt = bcd_inc(r_count);
          end else begin
            if (r_count == '0) begin
              w_count_nxt = MAX_BCD;
              w_wrap_nxt  = 1'b1;
            end else w_count_nxt = bcd_dec(r_count);
          end
        end
      end
      S_CONFIG: begin
        if (cfg_pulse) begin
          // BCD nibbles order the same as decimal values, so a plain compare works.
          if (r_edit <= MAX_BCD) w_count_nxt = r_edit;
          else begin
            w_count_nxt = MAX_BCD;
            w_clamp_nxt = 1'b1;
          end
          w_state_nxt  = S_COUNT;
          w_cursor_nxt = '0;
          w_off_nxt    = 1'b0;
        end else if (sel_pulse || adj_up_pulse || adj_dn_pulse) begin
          w_idle_nxt  = '0;
          w_blink_nxt = '0;
          w_off_nxt   = 1'b0;
          if (sel_pulse) begin
            w_cursor_nxt = (r_cursor == CW'(NUM_DIGITS - 1)) ? '0 : r_cursor + CW'(1);
          end else begin
            for (int i = 0; i < int'(NUM_DIGITS); i++) begin
              if (CW'(i) == r_cursor) begin
                if (adj_up_pulse)
                  w_edit_nxt[4*i +: 4] = (r_edit[4*i +: 4] == 4'd9) ? 4'd0 : r_edit[4*i +: 4] + 4'd1;
                else
                  w_edit_nxt[4*i +: 4] = (r_edit[4*i +: 4] == 4'd0) ? 4'd9 : r_edit[4*i +: 4] - 4'd1;
              end
            end
          end
        end else if (w_tmo_hit) begin
          w_state_nxt  = S_COUNT;
          w_cursor_nxt = '0;
          w_off_nxt    = 1'b0;
          w_tmo_nxt    = 1'b1;
        end else begin
          if (r_idle != '1) w_idle_nxt = r_idle + 32'd1;
          if (w_blink_hit) begin
            w_blink_nxt = '0;
            w_off_nxt   = ~r_off;
          end else w_blink_nxt = r_blink + 32'd1;
        end
      end
      default: w_state_nxt = S_COUNT;
    endcase

    w_bcd_nxt = (w_state_nxt == S_CONFIG) ? w_edit_nxt : w_count_nxt;
    w_blank_nxt = '0;
    for (int i = 0; i < int'(NUM_DIGITS); i++)
      w_blank_nxt[i] = (w_state_nxt == S_CONFIG) && w_off_nxt && (CW'(i) == w_cursor_nxt);
  end

  always_ff @(posedge clk) begin
    if (!reset_sw_n) begin
      r_state    <= S_COUNT;
      r_count    <= '0;
      r_edit     <= '0;
      r_cursor   <= '0;
      r_idle     <= '0;
      r_blink    <= '0;
      r_off      <= 1'b0;
      r_bcd_out  <= '0;
      r_cfg_mode <= 1'b0;
      r_blank    <= '0;
      r_wrap     <= 1'b0;
      r_clamp    <= 1'b0;
      r_tmo      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_count    <= w_count_nxt;
      r_edit     <= w_edit_nxt;
      r_cursor   <= w_cursor_nxt;
      r_idle     <= w_idle_nxt;
      r_blink    <= w_blink_nxt;
      r_off      <= w_off_nxt;
      r_bcd_out  <= w_bcd_nxt;
      r_cfg_mode <= (w_state_nxt == S_CONFIG);
      r_blank    <= w_blank_nxt;
      r_wrap     <= w_wrap_nxt;
      r_clamp    <= w_clamp_nxt;
      r_tmo      <= w_tmo_nxt;
    end
  end

  assign bcd_out       = r_bcd_out;
  assign cfg_mode      = r_cfg_mode;
  assign cursor        = r_cursor;
  assign blank_mask    = r_blank;
  assign wrap_pulse    = r_wrap;
  assign clamp_pulse   = r_clamp;
  assign timeout_pulse = r_tmo;

endmodule

// File: tb/tb_bcd_preset_counter.sv
// Scoreboard bench: two differently-parameterised counters share stimulus and
// are compared every cycle against an integer/digit-array reference model.
module tb_bcd_preset_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, en, inc, dec, cfg, sel, up, dn;

  logic [7:0]  a_bcd;  logic a_cfg; logic [0:0] a_cur; logic [1:0] a_blank;
  logic a_wrap, a_clamp, a_tmo;
  logic [11:0] b_bcd;  logic b_cfg; logic [1:0] b_cur; logic [2:0] b_blank;
  logic b_wrap, b_clamp, b_tmo;

  bcd_preset_counter #(.NUM_DIGITS(2), .MAX_VALUE(63), .CFG_TIMEOUT(20), .BLINK_HALF(4)) u_a (
    .clk(clk), .reset_sw_n(rst_n), .count_en(en), .inc_pulse(inc), .dec_pulse(dec),
    .cfg_pulse(cfg), .sel_pulse(sel), .adj_up_pulse(up), .adj_dn_pulse(dn),
    .bcd_out(a_bcd), .cfg_mode(a_cfg), .cursor(a_cur), .blank_mask(a_blank),
    .wrap_pulse(a_wrap), .clamp_pulse(a_clamp), .timeout_pulse(a_tmo));

  bcd_preset_counter #(.NUM_DIGITS(3), .MAX_VALUE(999), .CFG_TIMEOUT(0), .BLINK_HALF(3)) u_b (
    .clk(clk), .reset_sw_n(rst_n), .count_en(en), .inc_pulse(inc), .dec_pulse(dec),
    .cfg_pulse(cfg), .sel_pulse(sel), .adj_up_pulse(up), .adj_dn_pulse(dn),
    .bcd_out(b_bcd), .cfg_mode(b_cfg), .cursor(b_cur), .blank_mask(b_blank),
    .wrap_pulse(b_wrap), .clamp_pulse(b_clamp), .timeout_pulse(b_tmo));

  typedef struct packed {
    logic [31:0] bcd;
    logic        cfg;
    logic [7:0]  cur;
    logic [7:0]  blank;
    logic        wrap;
    logic        clamp;
    logic        tmo;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int nchk = 0;
  int nerr = 0;

  int P_ND[2]  = '{2, 3};
  int P_MAX[2] = '{63, 999};
  int P_TMO[2] = '{20, 0};
  int P_BLK[2] = '{4, 3};

  // Reference state: mode 0=count 1=config, s = cycles since last activity in config.
  int     m_mode[2];
  int     m_count[2];
  int     m_cur[2];
  longint m_s[2];
  int     m_edit[2][8];

  function automatic logic [31:0] int_bcd(input int k, input int v);
    logic [31:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < P_ND[k]; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int edit_val(input int k);
    int v;
    int w;
    v = 0;
    w = 1;
    for (int i = 0; i < P_ND[k]; i++) begin
      v = v + m_edit[k][i] * w;
      w = w * 10;
    end
    return v;
  endfunction

  task automatic model_step(input int k);
    exp_t e;
    logic w, c, t;
    w = 1'b0; c = 1'b0; t = 1'b0;
    if (!rst_n) begin
      m_mode[k] = 0; m_count[k] = 0; m_cur[k] = 0; m_s[k] = 0;
      for (int i = 0; i < 8; i++) m_edit[k][i] = 0;
    end else if (m_mode[k] == 0) begin
      if (cfg) begin
        m_mode[k] = 1; m_cur[k] = 0; m_s[k] = 0;
        for (int i = 0; i < 8; i++) m_edit[k][i] = (m_count[k] / (10 ** i)) % 10;
      end else if (en && (inc != dec)) begin
        if (inc) begin
          if (m_count[k] == P_MAX[k]) begin m_count[k] = 0; w = 1'b1; end
          else m_count[k] = m_count[k] + 1;
        end else begin
          if (m_count[k] == 0) begin m_count[k] = P_MAX[k]; w = 1'b1; end
          else m_count[k] = m_count[k] - 1;
        end
      end
    end else begin
      if (cfg) begin
        if (edit_val(k) > P_MAX[k]) begin m_count[k] = P_MAX[k]; c = 1'b1; end
        else m_count[k] = edit_val(k);
        m_mode[k] = 0; m_cur[k] = 0;
      end else if (sel) begin
        m_cur[k] = (m_cur[k] + 1) % P_ND[k]; m_s[k] = 0;
      end else if (up) begin
        m_edit[k][m_cur[k]] = (m_edit[k][m_cur[k]] + 1) % 10; m_s[k] = 0;
      end else if (dn) begin
        m_edit[k][m_cur[k]] = (m_edit[k][m_cur[k]] + 9) % 10; m_s[k] = 0;
      end else if (P_TMO[k] > 0 && m_s[k] + 1 == longint'(P_TMO[k])) begin
        m_mode[k] = 0; m_cur[k] = 0; t = 1'b1;
      end else m_s[k] = m_s[k] + 1;
    end
    e.bcd   = (m_mode[k] != 0) ? int_bcd(k, edit_val(k)) : int_bcd(k, m_count[k]);
    e.cfg   = (m_mode[k] != 0);
    e.cur   = 8'(m_cur[k]);
    e.blank = (m_mode[k] != 0 && ((m_s[k] / P_BLK[k]) % 2) == 1) ? 8'(1 << m_cur[k]) : 8'd0;
    e.wrap  = w;
    e.clamp = c;
    e.tmo   = t;
    if (k == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  function automatic exp_t got_of(input int k);
    exp_t g;
    g = '0;
    if (k == 0) begin
      g.bcd = 32'(a_bcd); g.cfg = a_cfg; g.cur = 8'(a_cur); g.blank = 8'(a_blank);
      g.wrap = a_wrap; g.clamp = a_clamp; g.tmo = a_tmo;
    end else begin
      g.bcd = 32'(b_bcd); g.cfg = b_cfg; g.cur = 8'(b_cur); g.blank = 8'(b_blank);
      g.wrap = b_wrap; g.clamp = b_clamp; g.tmo = b_tmo;
    end
    return g;
  endfunction

  task automatic step(input logic r, input logic e, input logic i, input logic d,
                      input logic c, input logic s, input logic u, input logic n);
    @(negedge clk);
    rst_n = r; en = e; inc = i; dec = d; cfg = c; sel = s; up = u; dn = n;
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    rst_n = 1'b1; inc = 1'b0; dec = 1'b0; cfg = 1'b0; sel = 1'b0; up = 1'b0; dn = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) step(1, 1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic incs(input int n);
    for (int j = 0; j < n; j++) step(1, 1, 1, 0, 0, 0, 0, 0);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic pick(input int pct);
    return ($urandom_range(0, 99) < pct);
  endfunction

  initial begin
    rst_n = 1'b0; en = 1'b0; inc = 1'b0; dec = 1'b0;
    cfg = 1'b0; sel = 1'b0; up = 1'b0; dn = 1'b0;

    fork
      begin : monitor
        exp_t e;
        exp_t g;
        bit   ok;
        forever begin
          @(posedge clk);
          #1;
          for (int k = 0; k < 2; k++) begin
            ok = 1'b0;
            if (k == 0 && q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
            if (k == 1 && q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
            if (ok) begin
              g = got_of(k);
              nchk++;
              if (g !== e) begin
                nerr++;
                $display("FAIL sb dut%0d t=%0t got bcd=%0h cfg=%0b cur=%0d blank=%b wct=%b%b%b expected bcd=%0h cfg=%0b cur=%0d blank=%b wct=%b%b%b",
                         k, $time, g.bcd, g.cfg, g.cur, g.blank, g.wrap, g.clamp, g.tmo,
                         e.bcd, e.cfg, e.cur, e.blank, e.wrap, e.clamp, e.tmo);
              end
            end
          end
        end
      end
    join_none

    // Reset, count to the limit, wrap both ways.
    step(0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    chk("rst_bcd", 32'(a_bcd), 32'h0);
    chk("rst_cfg", 32'(a_cfg), 32'h0);
    incs(63);
    chk("inc63", 32'(a_bcd), 32'h63);
    incs(1);
    chk("wrap_val", 32'(a_bcd), 32'h0);
    chk("wrap_pulse", 32'(a_wrap), 32'h1);
    idle(1);
    chk("wrap_one_cycle", 32'(a_wrap), 32'h0);
    step(1, 1, 0, 1, 0, 0, 0, 0);
    chk("dec_wrap_val", 32'(a_bcd), 32'h63);
    chk("dec_wrap_pulse", 32'(a_wrap), 32'h1);

    // Decimal carry / borrow, simultaneous inc+dec, count_en gating.
    step(0, 1, 0, 0, 0, 0, 0, 0);
    incs(9);
    incs(1);
    chk("carry", 32'(a_bcd), 32'h10);
    step(1, 1, 0, 1, 0, 0, 0, 0);
    chk("borrow", 32'(a_bcd), 32'h09);
    step(1, 1, 1, 1, 0, 0, 0, 0);
    chk("inc_dec_hold", 32'(a_bcd), 32'h09);
    step(1, 0, 1, 0, 0, 0, 0, 0);
    chk("en_low_hold", 32'(a_bcd), 32'h09);

    // Config edit and commit.
    step(0, 1, 0, 0, 0, 0, 0, 0);
    incs(27);
    step(1, 1, 0, 0, 1, 0, 0, 0);
    chk("enter_cfg", 32'(a_cfg), 32'h1);
    chk("enter_cur", 32'(a_cur), 32'h0);
    for (int j = 0; j < 8; j++) step(1, 1, 0, 0, 0, 0, 0, 1);
    chk("adj_dn_wrap", 32'(a_bcd), 32'h29);
    step(1, 1, 0, 0, 0, 1, 0, 0);
    chk("sel_cur", 32'(a_cur), 32'h1);
    for (int j = 0; j < 3; j++) step(1, 1, 0, 0, 0, 0, 1, 0);
    chk("adj_up", 32'(a_bcd), 32'h59);
    step(1, 1, 0, 0, 1, 0, 0, 0);
    chk("commit_val", 32'(a_bcd), 32'h59);
    chk("commit_noclamp", 32'(a_clamp), 32'h0);
    chk("commit_exit", 32'(a_cfg), 32'h0);

    // Clamped commit.
    step(1, 1, 0, 0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 1, 0, 0);
    for (int j = 0; j < 3; j++) step(1, 1, 0, 0, 0, 0, 1, 0);
    chk("edit87", 32'(a_bcd), 32'h87);
    step(1, 1, 0, 0, 1, 0, 0, 0);
    chk("clamp_val", 32'(a_bcd), 32'h63);
    chk("clamp_pulse", 32'(a_clamp), 32'h1);
    idle(1);
    chk("clamp_one_cycle", 32'(a_clamp), 32'h0);

    // Blink phases and idle timeout.
    step(0, 1, 0, 0, 0, 0, 0, 0);
    incs(12);
    step(1, 1, 0, 0, 1, 0, 0, 0);
    idle(4);
    chk("blink_off_pre", 32'(a_blank), 32'h1);
    step(1, 1, 0, 0, 0, 0, 1, 0);
    chk("blink_restart", 32'(a_blank), 32'h0);
    for (int j = 1; j <= 20; j++) begin
      idle(1);
      if (j < 20) chk("blink", 32'(a_blank), ((j / 4) % 2 == 1) ? 32'h1 : 32'h0);
    end
    chk("tmo_val", 32'(a_bcd), 32'h12);
    chk("tmo_pulse", 32'(a_tmo), 32'h1);
    chk("tmo_exit", 32'(a_cfg), 32'h0);
    idle(1);
    chk("tmo_one_cycle", 32'(a_tmo), 32'h0);

    // Commit on the would-be timeout cycle.
    step(1, 1, 0, 0, 1, 0, 0, 0);
    idle(19);
    step(1, 1, 0, 0, 1, 0, 0, 0);
    chk("cfg_beats_tmo", 32'(a_tmo), 32'h0);
    chk("cfg_beats_tmo_exit", 32'(a_cfg), 32'h0);

    // Reset during config discards the edit.
    step(0, 1, 0, 0, 0, 0, 0, 0);
    incs(45);
    step(1, 1, 0, 0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    chk("rst_cfg_bcd", 32'(a_bcd), 32'h0);
    chk("rst_cfg_mode", 32'(a_cfg), 32'h0);
    chk("rst_cfg_cur", 32'(a_cur), 32'h0);

    // Three-digit wrap at 999.
    step(0, 1, 0, 0, 0, 0, 0, 0);
    incs(999);
    chk("b_999", 32'(b_bcd), 32'h999);
    incs(1);
    chk("b_wrap_val", 32'(b_bcd), 32'h000);
    chk("b_wrap_pulse", 32'(b_wrap), 32'h1);

    // Randomised bursts at varying activity levels.
    for (int blk = 0; blk < 25; blk++) begin
      int lvl;
      int p;
      lvl = $urandom_range(0, 2);
      p = (lvl == 0) ? 1 : ((lvl == 1) ? 10 : 30);
      for (int j = 0; j < 80; j++)
        step(~pick(1), pick(80), pick(p), pick(p), pick(p / 3 + 1), pick(p), pick(p), pick(p));
    end

    repeat (3) @(negedge clk);
    nchk++;
    if (q0.size() + q1.size() != 0) begin
      nerr++;
      $display("FAIL sb_drain: got %0d pending expected 0", q0.size() + q1.size());
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/bcd_preset_counter.md
Name: bcd_preset_counter

Overview:
- Parametrised successor of the two-digit preset counter: an N-digit BCD up/down counter with a programmable wrap limit.
- Config mode edits one cursor-selected digit at a time. Commit clamps to the limit; an inactivity timeout aborts the edit.
- Sits between the button edge detectors (inputs are already single-cycle pulses) and the 7-segment display controller (consumes bcd_out and blank_mask).

Parameters:
- NUM_DIGITS, 2, number of BCD digits (1..8).
- MAX_VALUE, 63, inclusive count limit; must be < 10**NUM_DIGITS.
- CFG_TIMEOUT, 500_000_000, idle cycles in config before abort; 0 disables the timeout.
- BLINK_HALF, 25_000_000, cycles per blink half-period of the cursor digit (>=1).

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset_sw_n  in  1  synchronous, active-low reset
- count_en  in  1  gates inc_pulse/dec_pulse in count mode
- inc_pulse  in  1  count up by one
- dec_pulse  in  1  count down by one
- cfg_pulse  in  1  enter config / commit and exit config
- sel_pulse  in  1  move cursor to the next more-significant digit
- adj_up_pulse  in  1  selected digit +1, wraps 9->0
- adj_dn_pulse  in  1  selected digit -1, wraps 0->9
- bcd_out  out  4*NUM_DIGITS  displayed value, digit 0 = LSB nibble
- cfg_mode  out  1  high while in CONFIG
- cursor  out  max(1,$clog2(NUM_DIGITS))  selected digit index
- blank_mask  out  NUM_DIGITS  1 = blank this digit (blink off phase)
- wrap_pulse  out  1  one cycle on any count wrap
- clamp_pulse  out  1  one cycle when a commit was clamped
- timeout_pulse  out  1  one cycle when config was aborted by timeout

Behaviour:
- Reset (reset_sw_n low at a clk edge): state COUNT, count=0, edit=0, cursor=0, blink/idle timers=0. All outputs 0 the cycle after. Reset mid-config discards the edit buffer.
- Storage: count and edit are both BCD registers, NUM_DIGITS nibbles each. No binary intermediate.
- Both BCD registers hold only digits 0..9 at all times.
- bcd_out = edit in CONFIG, count in COUNT. Registered outputs update the cycle after the causing pulse.
- COUNT priority: cfg_pulse > (inc xor dec, only when count_en).
  - inc and dec together: no change.
  - Inc at MAX_VALUE -> 0 and wrap_pulse. Otherwise BCD +1 with decimal carry chain.
  - Dec at 0 -> MAX_VALUE and wrap_pulse. Otherwise BCD -1 with borrow chain.
- COUNT -> CONFIG on cfg_pulse: edit<=count, cursor<=0, timers cleared, cfg_mode<=1.
- CONFIG priority: cfg > sel > adj_up > adj_dn. Lower-priority pulses in the same cycle are ignored.
  - sel: cursor <= (cursor==NUM_DIGITS-1) ? 0 : cursor+1.
  - adj_up / adj_dn modify only edit[cursor]. No carry into neighbouring digits.
  - Any accepted CONFIG pulse restarts both the idle timer and the blink timer (blink phase = on).
  - Exit on cfg: if edit <= MAX_VALUE (decimal compare), count<=edit. Otherwise count<=MAX_VALUE and clamp_pulse. Then state COUNT, cursor<=0.
- Timeout: in CONFIG with CFG_TIMEOUT>0, the idle counter reaching CFG_TIMEOUT-1 returns to COUNT. count is unchanged, edit is discarded, timeout_pulse is raised.
  - A cfg_pulse in that same cycle wins: commit happens, no timeout_pulse.
- Blink: in CONFIG, phase toggles every BLINK_HALF cycles. blank_mask[cursor]=1 during the off phase, all other bits 0. blank_mask=0 in COUNT.
- Counter widths: idle and blink counters are 32-bit, saturating/clearing, never wrapping spuriously.
- Status pulses last exactly one cycle and are never asserted simultaneously.

Test Plan:
- Defaults, reset, 63 inc pulses -> bcd_out=0x63. 1 more inc -> 0x00 with one-cycle wrap_pulse. Dec at 0x00 -> 0x63 plus wrap_pulse.
- Count 0x09, inc -> 0x10 (decimal carry). Dec -> 0x09 (borrow). inc+dec same cycle -> 0x09 held. inc with count_en=0 -> held.
- Count 0x27, cfg -> cfg_mode=1, cursor=0. adj_dn x8 -> edit 0x29 (7->9 wrap). sel, adj_up x3 -> 0x59. cfg -> count 0x59, no clamp_pulse.
- Config edit to 0x87, cfg -> bcd_out=0x63, clamp_pulse=1 for exactly one cycle.
- CFG_TIMEOUT=20, BLINK_HALF=4: enter config at 0x12, adj_up at cycle 5, then idle.
  - blank_mask alternates 01/00 every 4 cycles, restarting at the pulse.
  - Timeout fires 20 cycles after the last pulse: bcd_out=0x12, timeout_pulse.
- reset_sw_n low during CONFIG with edit 0x45 -> next cycle bcd_out=0x00, cfg_mode=0, cursor=0. NUM_DIGITS=3, MAX_VALUE=999: 999 inc -> 0x999, next inc -> 0x000.
